// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Start/ready handshake bundle for the sequential divider.
//               master : drives start/A/B, observes results
//               slave  : the divider itself
//   start        request pulse, sampled only while ready=1
//   A, B         signed dividend / divisor (NB bits)
//   Quotient     signed quotient, valid while ready=1
//   Remainder    signed remainder (sign follows dividend), valid while ready=1
//   ready        1 = idle with results valid, 0 = busy
//   div_by_zero  last completed operation had B=0
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int NB = 32
);
    logic          start;
    logic [NB-1:0] A;
    logic [NB-1:0] B;
    logic [NB-1:0] Quotient;
    logic [NB-1:0] Remainder;
    logic          ready;
    logic          div_by_zero;

    modport master (
        output start, A, B,
        input  Quotient, Remainder, ready, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output Quotient, Remainder, ready, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle signed restoring divider. Works on magnitudes,
//               one quotient bit per clock, then applies signs so results
//               truncate toward zero (same as Verilog signed "/" and "%").
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   seq_divider_if.slave (start, A, B, Quotient, Remainder, ready,
//         div_by_zero)
//   Latency: ready returns high on the (NB+1)-th edge after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int NB = 32
) (
    input  wire           clk,
    input  wire           rst,
    seq_divider_if.slave  bus
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] c_last_step = CW'(NB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [NB-1:0] r_rem;    // partial remainder; always < |B| after a step
    logic [NB-1:0] r_dvd;    // dividend magnitude, becomes the quotient
    logic [NB-1:0] r_dvs;    // divisor magnitude
    logic          r_sa;     // dividend sign -> remainder sign
    logic          r_sq;     // quotient sign
    logic          r_bzero;
    logic [NB-1:0] r_quot;
    logic [NB-1:0] r_remo;
    logic          r_ready;
    logic          r_dbz;

    logic          w_accept;
    logic [NB-1:0] w_abs_a;
    logic [NB-1:0] w_abs_b;
    logic [NB:0]   w_shift;  // {rem, next dividend bit}: needs one extra bit
    logic [NB:0]   w_trial;

    // The most negative value negates to itself, which is the correct
    // unsigned magnitude 2^(NB-1).
    assign w_abs_a  = bus.A[NB-1] ? (~bus.A + 1'b1) : bus.A;
    assign w_abs_b  = bus.B[NB-1] ? (~bus.B + 1'b1) : bus.B;
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_shift  = {r_rem, r_dvd[NB-1]};
    assign w_trial  = w_shift - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == c_last_step) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_sa    <= 1'b0;
            r_sq    <= 1'b0;
            r_bzero <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_ready <= 1'b1;
            r_dbz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dvd   <= w_abs_a;
                r_dvs   <= w_abs_b;
                r_sa    <= bus.A[NB-1];
                r_sq    <= bus.A[NB-1] ^ bus.B[NB-1];
                r_bzero <= (bus.B == '0);
                r_rem   <= '0;
                r_cnt   <= '0;
                r_ready <= 1'b0;
            end
            if (r_state == S_CALC) begin
                // Restoring step: keep the difference only if it did not
                // borrow; a zero divisor therefore yields all ones.
                if (!w_trial[NB]) begin
                    r_rem <= w_trial[NB-1:0];
                    r_dvd <= {r_dvd[NB-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[NB-1:0];
                    r_dvd <= {r_dvd[NB-2:0], 1'b0};
                end
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_FIX) begin
                r_quot  <= r_sq ? -r_dvd : r_dvd;
                r_remo  <= r_sa ? -r_rem : r_rem;
                r_dbz   <= r_bzero;
                r_ready <= 1'b1;
            end
        end
    end

    assign bus.Quotient    = r_quot;
    assign bus.Remainder   = r_remo;
    assign bus.ready       = r_ready;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider. Directed cases, restart
//               and reset-abort cases, then random operand pairs compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int NB = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_divider_if #(.NB(NB)) dif ();

    seq_divider #(.NB(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed truncating division done in 64-bit arithmetic, so
    // the -2^31 / -1 case simply wraps when cut back to 32 bits.
    function automatic void ref_div(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                    output logic [NB-1:0] q, output logic [NB-1:0] r,
                                    output logic dz);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            dz = 1'b1;
            q  = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
            r  = a;
        end else begin
            dz = 1'b0;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation; poke >= 0 re-pulses start (with other operands) that
    // many edges into the busy period, which must be ignored.
    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input int poke, input string tag);
        logic [NB-1:0] eq;
        logic [NB-1:0] er;
        logic          ed;
        logic [NB-1:0] prev_q;
        logic [NB-1:0] prev_r;
        int            lat;
        ref_div(a, b, eq, er, ed);
        prev_q = dif.Quotient;
        prev_r = dif.Remainder;
        @(negedge clk);
        dif.start = 1'b1;
        dif.A     = a;
        dif.B     = b;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.A     = 'x;
        dif.B     = 'x;
        check({tag, ".busy"}, {31'd0, dif.ready}, 32'd0);
        check({tag, ".holdQ"}, dif.Quotient, prev_q);
        lat = 0;
        while (!dif.ready && lat < 40) begin
            if (lat == poke) begin
                dif.start = 1'b1;
                dif.A     = 32'd5;
                dif.B     = 32'd1;
            end
            @(posedge clk);
            #1;
            dif.start = 1'b0;
            lat++;
            if (lat == 1) check({tag, ".holdR"}, dif.Remainder, prev_r);
        end
        check({tag, ".latency"}, 32'(lat), 32'd33);
        check({tag, ".Q"}, dif.Quotient, eq);
        check({tag, ".R"}, dif.Remainder, er);
        check({tag, ".dbz"}, {31'd0, dif.div_by_zero}, {31'd0, ed});
    endtask

    initial begin
        logic [NB-1:0] ra;
        logic [NB-1:0] rb;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        dif.start = 1'b0;
        dif.A     = '0;
        dif.B     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", {31'd0, dif.ready}, 32'd1);
        check("rst.Q", dif.Quotient, 32'd0);
        check("rst.R", dif.Remainder, 32'd0);
        check("rst.dbz", {31'd0, dif.div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, -1, "p_p");
        run_op(-32'sd100, 32'd7, -1, "n_p");
        run_op(32'd100, -32'sd7, -1, "p_n");
        run_op(-32'sd100, -32'sd7, -1, "n_n");
        run_op(32'd1234, 32'd0, -1, "dz_pos");
        run_op(-32'sd1234, 32'd0, -1, "dz_neg");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, "ovf");
        run_op(32'h8000_0000, 32'd1, -1, "min_1");
        run_op(32'd7, 32'd100, -1, "small");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, -1, "max_min");
        run_op(32'd100, 32'd7, 10, "restart");

        // Abort in the middle of an operation.
        run_op(32'd9, 32'd2, -1, "pre_rst");
        @(negedge clk);
        dif.start = 1'b1;
        dif.A     = 32'd5000;
        dif.B     = 32'd3;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.ready", {31'd0, dif.ready}, 32'd1);
        check("abort.Q", dif.Quotient, 32'd0);
        check("abort.R", dif.Remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd5000, 32'd3, -1, "after_rst");

        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(0, 255)) - 32'd128;
            if (i % 5 == 0) ra = 32'($urandom_range(0, 2047)) - 32'd1024;
            if (rb == '0) rb = 32'd3;
            run_op(ra, rb, -1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
